// File: rtl/types.sv
`default_nettype none
// ============================================================================
//  Package    : types
//  Purpose    : Shared snoop-bus types for the cache controllers and the bus
//               arbiter: CPU count, bus transaction kinds, the bus message
//               record and the arbiter state encoding.
//  Revision   : 1.0  initial release
// ============================================================================
package types;

    localparam int NUM_CPUS    = 4;
    localparam int CPU_ID_W    = (NUM_CPUS > 1) ? $clog2(NUM_CPUS) : 1;
    localparam int ADDR_W      = 32;
    localparam int ARB_TIMEOUT = 64;

    typedef logic [CPU_ID_W-1:0] cpu_id_t;

    typedef enum logic [2:0] {
        Bus_Idle  = 3'd0,
        Bus_Rd    = 3'd1,
        Bus_Rdx   = 3'd2,
        Bus_Upg   = 3'd3,
        Bus_Flush = 3'd4
    } bus_tx_t;

    typedef struct packed {
        logic              valid;
        bus_tx_t           bus_tx;
        cpu_id_t           source;
        logic [ADDR_W-1:0] addr;
    } bus_msg_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BCAST = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    // Upgrades only invalidate other copies; every other transaction also
    // needs the memory/crossbar side to finish before the bus is released.
    function automatic logic tx_needs_mem(input bus_tx_t tx);
        return (tx == Bus_Rd) || (tx == Bus_Rdx) || (tx == Bus_Flush);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module     : rr_arbiter
//  Purpose    : Combinational round-robin winner selection. The search starts
//               at i_ptr and wraps upward modulo NUM_REQ.
//  Ports      : i_req    - request vector
//               i_ptr    - highest-priority index for this cycle
//               o_winner - one-hot winner (all zero when nobody requests)
//               o_valid  - at least one request present
//  Revision   : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_winner,
    output logic               o_valid
);

    int w_dist;
    int w_best;
    int w_sel;

    // Each index gets its circular distance from the pointer; the requester
    // with the smallest distance wins. Distances are unique, so no ties.
    always_comb begin
        w_dist   = 0;
        w_best   = NUM_REQ;
        w_sel    = 0;
        o_winner = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_dist = (k >= int'(i_ptr)) ? (k - int'(i_ptr))
                                        : (k + NUM_REQ - int'(i_ptr));
            if (i_req[k] && (w_dist < w_best)) begin
                w_best = w_dist;
                w_sel  = k;
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            o_winner[k] = (w_best < NUM_REQ) && (k == w_sel);
        end
    end

    assign o_valid = |i_req;

endmodule
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module     : bus_arbiter
//  Purpose    : Snoop-bus arbiter for NUM_CPUS cache controllers. Grants one
//               CPU round-robin, broadcasts its message for one cycle, then
//               holds the grant until every other CPU has snooped and (when
//               needed) memory has responded, or until a timeout expires.
//  Ports      : clk, rst        - clock, synchronous active-high reset
//               req_i/req_msg_i - per-CPU request and pending message
//               gnt_o           - one-hot grant, held for the transaction
//               bus_o           - broadcast message, valid in BCAST only
//               snoop_done_i    - per-CPU snoop completion
//               mem_done_i      - memory/xbar completion
//               busy_o          - transaction in progress
//               timeout_o       - one-cycle pulse on forced release
//  Revision   : 1.0  initial release
// ============================================================================
module bus_arbiter
    import types::*;
#(
    parameter int NUM_CPUS       = types::NUM_CPUS,
    parameter int TIMEOUT_CYCLES = types::ARB_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_CPUS-1:0] req_i,
    input  bus_msg_t            req_msg_i [NUM_CPUS],
    output logic [NUM_CPUS-1:0] gnt_o,
    output bus_msg_t            bus_o,
    input  logic [NUM_CPUS-1:0] snoop_done_i,
    input  logic                mem_done_i,
    output logic                busy_o,
    output logic                timeout_o
);

    localparam int c_PTR_W = (NUM_CPUS > 1) ? $clog2(NUM_CPUS) : 1;
    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [NUM_CPUS-1:0] w_req;
    logic [NUM_CPUS-1:0] w_win;
    logic                w_win_valid;
    logic [c_PTR_W-1:0]  w_win_idx;
    logic [c_PTR_W-1:0]  w_next_ptr;
    bus_msg_t            w_grant_msg;
    logic [NUM_CPUS-1:0] w_snoop_acc;
    logic                w_mem_acc;
    logic                w_complete;

    arb_state_t          r_state;
    logic [c_PTR_W-1:0]  r_ptr;
    logic [NUM_CPUS-1:0] r_gnt;
    logic [NUM_CPUS-1:0] r_snoop_done;
    logic                r_mem_done;
    bus_tx_t             r_tx;
    bus_msg_t            r_bus;
    logic                r_busy;
    logic                r_timeout;
    logic [c_CNT_W-1:0]  r_wait_cnt;

    for (genvar k = 0; k < NUM_CPUS; k++) begin : g_req
        assign w_req[k] = req_i[k] && req_msg_i[k].valid &&
                          (req_msg_i[k].bus_tx != Bus_Idle);
    end

    rr_arbiter #(
        .NUM_REQ (NUM_CPUS),
        .PTR_W   (c_PTR_W)
    ) u_rr_arbiter (
        .i_req    (w_req),
        .i_ptr    (r_ptr),
        .o_winner (w_win),
        .o_valid  (w_win_valid)
    );

    always_comb begin
        w_win_idx = '0;
        for (int k = 0; k < NUM_CPUS; k++) begin
            if (w_win[k]) w_win_idx = c_PTR_W'(k);
        end
    end

    assign w_next_ptr = (int'(w_win_idx) == NUM_CPUS - 1) ? '0
                                                         : w_win_idx + c_PTR_W'(1);

    // The source field is always rewritten to the real winner so a CPU cannot
    // broadcast under another CPU's identity.
    always_comb begin
        w_grant_msg        = req_msg_i[w_win_idx];
        w_grant_msg.valid  = 1'b1;
        w_grant_msg.source = cpu_id_t'(w_win_idx);
    end

    // The source never snoops its own request, so its bit is forced via the
    // one-hot grant. Inputs arriving this cycle count immediately.
    assign w_snoop_acc = r_snoop_done | snoop_done_i | r_gnt;
    assign w_mem_acc   = r_mem_done | mem_done_i;
    assign w_complete  = (&w_snoop_acc) && (!tx_needs_mem(r_tx) || w_mem_acc);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_ptr        <= '0;
            r_gnt        <= '0;
            r_snoop_done <= '0;
            r_mem_done   <= 1'b0;
            r_tx         <= Bus_Idle;
            r_bus        <= '0;
            r_busy       <= 1'b0;
            r_timeout    <= 1'b0;
            r_wait_cnt   <= '0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_win_valid) begin
                        r_state      <= BCAST;
                        r_gnt        <= w_win;
                        r_busy       <= 1'b1;
                        r_ptr        <= w_next_ptr;
                        r_tx         <= w_grant_msg.bus_tx;
                        r_bus        <= w_grant_msg;
                        r_snoop_done <= '0;
                        r_mem_done   <= 1'b0;
                        r_wait_cnt   <= '0;
                    end
                end
                BCAST: begin
                    r_state      <= WAIT;
                    r_bus        <= '0;
                    r_snoop_done <= w_snoop_acc;
                    r_mem_done   <= w_mem_acc;
                end
                WAIT: begin
                    if (w_complete ||
                        (r_wait_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1))) begin
                        r_state      <= IDLE;
                        r_gnt        <= '0;
                        r_busy       <= 1'b0;
                        r_snoop_done <= '0;
                        r_mem_done   <= 1'b0;
                        r_wait_cnt   <= '0;
                        r_timeout    <= !w_complete;
                    end else begin
                        r_snoop_done <= w_snoop_acc;
                        r_mem_done   <= w_mem_acc;
                        r_wait_cnt   <= r_wait_cnt + c_CNT_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign gnt_o     = r_gnt;
    assign bus_o     = r_bus;
    assign busy_o    = r_busy;
    assign timeout_o = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module     : tb_bus_arbiter
//  Purpose    : Self-checking bench for bus_arbiter: directed scenarios plus a
//               randomized run against a transaction-level reference model.
//  Revision   : 1.0  initial release
// ============================================================================
module tb_bus_arbiter;
    import types::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_i;
    bus_msg_t   req_msg_i [4];
    logic [3:0] gnt_o;
    bus_msg_t   bus_o;
    logic [3:0] snoop_done_i;
    logic       mem_done_i;
    logic       busy_o;
    logic       timeout_o;

    int checks   = 0;
    int failures = 0;

    bus_tx_t     pend_tx [4];
    logic [31:0] addr_q  [4];
    int          model_ptr;

    logic [3:0]  obs_gnt  [0:70];
    logic        obs_busy [0:70];
    logic        obs_to   [0:70];
    bus_msg_t    obs_bus  [0:70];

    bus_arbiter #(
        .NUM_CPUS       (4),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req_i),
        .req_msg_i    (req_msg_i),
        .gnt_o        (gnt_o),
        .bus_o        (bus_o),
        .snoop_done_i (snoop_done_i),
        .mem_done_i   (mem_done_i),
        .busy_o       (busy_o),
        .timeout_o    (timeout_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int model_winner();
        for (int i = 0; i < 4; i++) begin
            if (pend_tx[(model_ptr + i) % 4] != Bus_Idle) return (model_ptr + i) % 4;
        end
        return -1;
    endfunction

    // Last offset (0 = broadcast cycle) during which the grant is still held.
    function automatic int model_end(input int sa[4], input int ma, input int w,
                                     input bus_tx_t t, output bit to);
        int last;
        last = 1;
        to   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k != w) begin
                if (sa[k] < 0) to = 1'b1;
                else if (sa[k] > last) last = sa[k];
            end
        end
        if (t == Bus_Rd || t == Bus_Rdx || t == Bus_Flush) begin
            if (ma < 0) to = 1'b1;
            else if (ma > last) last = ma;
        end
        if (last > ARB_TIMEOUT) to = 1'b1;
        return to ? ARB_TIMEOUT : last;
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic apply_req();
        for (int k = 0; k < 4; k++) begin
            bus_msg_t m;
            m.addr   = addr_q[k];
            m.source = cpu_id_t'($urandom_range(0, 3));
            if (pend_tx[k] != Bus_Idle) begin
                req_i[k] = 1'b1; m.valid = 1'b1; m.bus_tx = pend_tx[k];
            end else begin
                case ($urandom_range(0, 2))
                    0:       begin req_i[k] = 1'b0; m.valid = 1'b1; m.bus_tx = Bus_Rd;   end
                    1:       begin req_i[k] = 1'b1; m.valid = 1'b0; m.bus_tx = Bus_Rdx;  end
                    default: begin req_i[k] = 1'b1; m.valid = 1'b1; m.bus_tx = Bus_Idle; end
                endcase
            end
            req_msg_i[k] = m;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        snoop_done_i = '0;
        mem_done_i   = 1'b0;
        model_ptr    = 0;
        for (int k = 0; k < 4; k++) begin
            pend_tx[k] = Bus_Idle;
            addr_q[k]  = $urandom;
        end
        apply_req();
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Called while the DUT is idle with requests visible. Runs offsets
    // 0..len, pulsing done inputs at their scheduled offsets, and records
    // outputs at each falling edge. The last offset drives random dones,
    // which the DUT must ignore because it is idle then.
    task automatic capture(input int w, input int sa[4], input int ma,
                           input int len, input bit keep);
        for (int off = 0; off <= len; off++) begin
            @(posedge clk); #1;
            if (off == len) begin
                snoop_done_i = 4'($urandom);
                mem_done_i   = 1'($urandom);
            end else begin
                for (int k = 0; k < 4; k++) snoop_done_i[k] = (sa[k] == off);
                mem_done_i = (ma == off);
            end
            if (off == 0 && !keep) pend_tx[w] = Bus_Idle;
            if (off >= 1 && off < len) addr_q[$urandom_range(0, 3)] = $urandom;
            apply_req();
            @(negedge clk);
            obs_gnt[off]  = gnt_o;
            obs_busy[off] = busy_o;
            obs_to[off]   = timeout_o;
            obs_bus[off]  = bus_o;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks += 4;
        if (gnt_o !== 4'b0)     begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt_o); end
        if (busy_o !== 1'b0)    begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        if (timeout_o !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", timeout_o); end
        if (bus_o !== '0)       begin failures++; $display("FAIL reset_bus got=%h exp=0", bus_o); end
    endtask

    task automatic test_rr_pair();
        int sa[4];
        do_reset();
        pend_tx[1] = Bus_Rd;
        pend_tx[2] = Bus_Rdx;
        apply_req();
        sa = '{1, -1, 1, 1};
        capture(1, sa, 1, 2, 1'b0);
        checks += 4;
        if (obs_gnt[0] !== 4'b0010)     begin failures++; $display("FAIL pair_first_gnt got=%b exp=0010", obs_gnt[0]); end
        if (obs_bus[0].source !== 2'd1 || obs_bus[0].valid !== 1'b1)
            begin failures++; $display("FAIL pair_first_bus got=%h exp src=1 valid=1", obs_bus[0]); end
        if (obs_bus[1] !== '0)          begin failures++; $display("FAIL pair_bus_one_cycle got=%h exp=0", obs_bus[1]); end
        if (obs_gnt[2] !== 4'b0000)     begin failures++; $display("FAIL pair_release got=%b exp=0000", obs_gnt[2]); end
        sa = '{1, 1, -1, 1};
        capture(2, sa, 1, 2, 1'b0);
        checks += 2;
        if (obs_gnt[0] !== 4'b0100)     begin failures++; $display("FAIL pair_second_gnt got=%b exp=0100", obs_gnt[0]); end
        if (obs_bus[0].source !== 2'd2 || obs_bus[0].bus_tx !== Bus_Rdx)
            begin failures++; $display("FAIL pair_second_bus got=%h exp src=2 Rdx", obs_bus[0]); end
    endtask

    task automatic test_upgrade_no_mem();
        int sa[4];
        int e;
        do_reset();
        pend_tx[3] = Bus_Upg;
        apply_req();
        e = 1;
        for (int k = 0; k < 3; k++) begin
            sa[k] = $urandom_range(0, 3);
            if (sa[k] > e) e = sa[k];
        end
        sa[3] = -1;
        capture(3, sa, -1, e + 1, 1'b0);
        checks += 3;
        if (obs_gnt[e] !== 4'b1000)     begin failures++; $display("FAIL upg_held off=%0d got=%b exp=1000", e, obs_gnt[e]); end
        if (obs_gnt[e+1] !== 4'b0000)   begin failures++; $display("FAIL upg_release off=%0d got=%b exp=0000", e + 1, obs_gnt[e+1]); end
        if (obs_to[e+1] !== 1'b0)       begin failures++; $display("FAIL upg_timeout got=%b exp=0", obs_to[e+1]); end
    endtask

    task automatic test_mem_release();
        int sa[4];
        do_reset();
        pend_tx[0] = Bus_Rd;
        apply_req();
        sa = '{-1, 1, 2, 1};
        capture(0, sa, 5, 6, 1'b0);
        checks += 4;
        if (obs_gnt[4] !== 4'b0001)  begin failures++; $display("FAIL mem_wait4 got=%b exp=0001", obs_gnt[4]); end
        if (obs_gnt[5] !== 4'b0001)  begin failures++; $display("FAIL mem_wait5 got=%b exp=0001", obs_gnt[5]); end
        if (obs_gnt[6] !== 4'b0000)  begin failures++; $display("FAIL mem_release got=%b exp=0000", obs_gnt[6]); end
        if (obs_busy[6] !== 1'b0)    begin failures++; $display("FAIL mem_busy got=%b exp=0", obs_busy[6]); end
    endtask

    task automatic test_timeout();
        int sa[4];
        logic early;
        do_reset();
        pend_tx[2] = Bus_Rdx;
        apply_req();
        sa = '{-1, -1, -1, -1};
        capture(2, sa, -1, 65, 1'b0);
        early = 1'b0;
        for (int off = 0; off <= 64; off++) early |= obs_to[off];
        checks += 4;
        if (early !== 1'b0)          begin failures++; $display("FAIL to_early got=%b exp=0", early); end
        if (obs_gnt[64] !== 4'b0100) begin failures++; $display("FAIL to_held64 got=%b exp=0100", obs_gnt[64]); end
        if (obs_to[65] !== 1'b1)     begin failures++; $display("FAIL to_pulse got=%b exp=1", obs_to[65]); end
        if (obs_gnt[65] !== 4'b0000) begin failures++; $display("FAIL to_release got=%b exp=0000", obs_gnt[65]); end
        for (int k = 0; k < 4; k++) pend_tx[k] = Bus_Rd;
        apply_req();
        sa = '{1, 1, 1, 1};
        capture(3, sa, 1, 2, 1'b0);
        checks += 2;
        if (obs_gnt[0] !== 4'b1000)  begin failures++; $display("FAIL to_ptr3 got=%b exp=1000", obs_gnt[0]); end
        if (obs_to[0] !== 1'b0)      begin failures++; $display("FAIL to_single_pulse got=%b exp=0", obs_to[0]); end
    endtask

    task automatic test_back_to_back();
        int sa[4];
        logic [3:0] eg;
        do_reset();
        for (int k = 0; k < 4; k++) pend_tx[k] = Bus_Rd;
        apply_req();
        sa = '{1, 1, 1, 1};
        for (int t = 0; t < 5; t++) begin
            capture(t % 4, sa, 1, 2, 1'b1);
            eg = '0;
            eg[t % 4] = 1'b1;
            checks += 2;
            if (obs_gnt[0] !== eg)      begin failures++; $display("FAIL b2b_gnt t=%0d got=%b exp=%b", t, obs_gnt[0], eg); end
            if (obs_gnt[2] !== 4'b0000) begin failures++; $display("FAIL b2b_gap t=%0d got=%b exp=0000", t, obs_gnt[2]); end
        end
    endtask

    task automatic test_reset_mid();
        int sa[4];
        do_reset();
        pend_tx[2] = Bus_Rdx;
        apply_req();
        sa = '{-1, -1, -1, -1};
        capture(2, sa, -1, 5, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        pend_tx[1] = Bus_Rd;
        pend_tx[3] = Bus_Rd;
        apply_req();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks += 3;
        if (gnt_o !== 4'b0000)  begin failures++; $display("FAIL rstmid_gnt got=%b exp=0000", gnt_o); end
        if (busy_o !== 1'b0)    begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy_o); end
        if (timeout_o !== 1'b0) begin failures++; $display("FAIL rstmid_timeout got=%b exp=0", timeout_o); end
        @(posedge clk); #1;
        @(negedge clk);
        checks += 2;
        if (gnt_o !== 4'b0010)  begin failures++; $display("FAIL rstmid_ptr0 got=%b exp=0010", gnt_o); end
        if (timeout_o !== 1'b0) begin failures++; $display("FAIL rstmid_no_to got=%b exp=0", timeout_o); end
    endtask

    task automatic test_random();
        int sa[4];
        int ma, w, e, len;
        bit to;
        bus_msg_t eb;
        logic [3:0] eg;
        logic ebusy, eto;
        bit any;
        do_reset();
        pend_tx[$urandom_range(0, 3)] = bus_tx_t'($urandom_range(1, 4));
        apply_req();
        for (int t = 0; t < 40; t++) begin
            w = model_winner();
            if (w < 0) begin
                failures++; checks++;
                $display("FAIL rand_model_no_requester t=%0d", t);
                break;
            end
            for (int k = 0; k < 4; k++)
                sa[k] = ($urandom_range(0, 15) == 0) ? -1 : int'($urandom_range(0, 7));
            ma = ($urandom_range(0, 15) == 0) ? -1 : int'($urandom_range(0, 7));
            e   = model_end(sa, ma, w, pend_tx[w], to);
            len = e + 1;
            eb        = '0;
            eb.valid  = 1'b1;
            eb.bus_tx = pend_tx[w];
            eb.source = cpu_id_t'(w);
            eb.addr   = addr_q[w];
            model_ptr = (w + 1) % 4;
            capture(w, sa, ma, len, 1'b0);
            for (int off = 0; off <= len; off++) begin
                eg = '0;
                if (off <= e) eg[w] = 1'b1;
                ebusy = (off <= e);
                eto   = (off == e + 1) && to;
                checks += 4;
                if (obs_gnt[off] !== eg)
                    begin failures++; $display("FAIL rand_gnt t=%0d off=%0d got=%b exp=%b", t, off, obs_gnt[off], eg); end
                if (obs_busy[off] !== ebusy)
                    begin failures++; $display("FAIL rand_busy t=%0d off=%0d got=%b exp=%b", t, off, obs_busy[off], ebusy); end
                if (obs_to[off] !== eto)
                    begin failures++; $display("FAIL rand_timeout t=%0d off=%0d got=%b exp=%b", t, off, obs_to[off], eto); end
                if (obs_bus[off] !== ((off == 0) ? eb : bus_msg_t'('0)))
                    begin failures++; $display("FAIL rand_bus t=%0d off=%0d got=%h exp=%h", t, off, obs_bus[off], (off == 0) ? eb : bus_msg_t'('0)); end
            end
            any = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (pend_tx[k] == Bus_Idle && $urandom_range(0, 1) == 1)
                    pend_tx[k] = bus_tx_t'($urandom_range(1, 4));
                if (pend_tx[k] != Bus_Idle) any = 1'b1;
            end
            if (!any) pend_tx[$urandom_range(0, 3)] = bus_tx_t'($urandom_range(1, 4));
            apply_req();
        end
    endtask

    initial begin
        rst          = 1'b1;
        req_i        = '0;
        snoop_done_i = '0;
        mem_done_i   = 1'b0;
        for (int k = 0; k < 4; k++) req_msg_i[k] = '0;
        test_reset();
        test_rr_pair();
        test_upgrade_no_mem();
        test_mem_release();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter NUM_CPUS, default types::NUM_CPUS (4), number of requesting cache controllers.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64, maximum WAIT duration before forced release.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_i  input  NUM_CPUS  per-CPU bus request; held high until granted.
REQ-006 SHALL have port req_msg_i  input  NUM_CPUS x bus_msg_t  per-CPU pending bus message.
REQ-007 SHALL have port gnt_o  output  NUM_CPUS  one-hot grant; high for the whole transaction.
REQ-008 SHALL have port bus_o  output  bus_msg_t  broadcast snoop-bus message.
REQ-009 SHALL have port snoop_done_i  input  NUM_CPUS  per-CPU snoop-complete pulse or level.
REQ-010 SHALL have port mem_done_i  input  1  memory/xbar response complete for the current transaction.
REQ-011 SHALL have port busy_o  output  1  high while a transaction is in progress (BCAST or WAIT).
REQ-012 SHALL have port timeout_o  output  1  one-cycle pulse on forced release.

Function
REQ-013 SHALL treat CPU k as requesting only when req_i[k]=1 and req_msg_i[k].valid=1 and req_msg_i[k].bus_tx!=Bus_Idle.
REQ-014 SHALL implement states IDLE, BCAST, WAIT.
REQ-015 IDLE: if any CPU requesting in cycle N, SHALL pick winner k round-robin and enter BCAST at N+1; else stay IDLE.
REQ-016 Round-robin: SHALL search from pointer ptr upward mod NUM_CPUS; on grant to k, ptr <= (k+1) mod NUM_CPUS.
REQ-017 SHALL register winner's message at grant; bus_o = latched message with source overwritten by k, valid=1 only in the BCAST cycle.
REQ-018 gnt_o[k] SHALL be 1 from BCAST through last WAIT cycle; all other gnt_o bits 0.
REQ-019 BCAST SHALL last exactly one cycle, then WAIT.
REQ-020 SHALL accumulate sticky done bits from snoop_done_i of all CPUs except source, sampled from BCAST cycle onward.
REQ-021 SHALL require mem_done_i (sticky, sampled from BCAST onward) for Bus_Rd, Bus_Rdx, Bus_Flush; Bus_Upg SHALL not require it.
REQ-022 When all required done bits are set (including in the same cycle they arrive), SHALL return to IDLE next cycle; gnt_o drops there.
REQ-023 Back-to-back: gnt_o SHALL be low at least one cycle between transactions; next grant earliest one cycle after return to IDLE.
REQ-024 SHALL count WAIT cycles; upon reaching TIMEOUT_CYCLES without completion, SHALL pulse timeout_o, clear done bits, return to IDLE.
REQ-025 When not in BCAST, bus_o SHALL be all-zero (valid=0, bus_tx=Bus_Idle).
REQ-026 Requests changing while granted SHALL not affect the latched message or current transaction.
REQ-027 snoop_done_i/mem_done_i in IDLE SHALL be ignored.

Reset
REQ-028 On rst=1 at a clock edge: state=IDLE, ptr=0, gnt_o=0, bus_o=0, busy_o=0, timeout_o=0, done bits and counter cleared.
REQ-029 Reset mid-transaction SHALL abandon it immediately; no completion or timeout is signalled.

Structure
REQ-030 arb_state_t enum (IDLE, BCAST, WAIT) and ARB_TIMEOUT default SHALL be added to package types; bus_msg_t and bus_tx_t reused from it.
REQ-031 Winner selection SHALL be a combinational sub-module rr_arbiter (inputs request vector, ptr; outputs one-hot winner, valid).

Verification
REQ-032 After reset, req_i=4'b0110 (CPU1 Bus_Rd, CPU2 Bus_Rdx) -> CPU1 granted first, bus_o.source=1 for one cycle; after completion CPU2 granted.
REQ-033 CPU3 Bus_Upg; snoop_done_i from CPU0,1,2 within 3 cycles, mem_done_i never -> release without mem_done, gnt_o low next cycle.
REQ-034 CPU0 Bus_Rd; all snoops done, mem_done_i at WAIT cycle 5 -> release exactly one cycle after mem_done_i.
REQ-035 CPU2 Bus_Rdx; no done inputs -> timeout_o pulses after 64 WAIT cycles, state IDLE, ptr=3.
REQ-036 All four requesting continuously -> grant order 0,1,2,3,0, one idle cycle between grants.
REQ-037 rst asserted during WAIT -> next cycle gnt_o=0, busy_o=0, ptr=0, no timeout_o.
